// File: rtl/dmem_arbiter_if.sv
// Signal bundle linking the data-memory arbiter to the CPU port, the waveform
// stream consumer and the single-port data memory.
interface dmem_arbiter_if #(
  parameter int LEN_W = 8
);
  logic             cpu_req;
  logic             cpu_we;
  logic [31:0]      cpu_addr;
  logic [31:0]      cpu_wdata;
  logic             cpu_gnt;
  logic             cpu_rvalid;
  logic [31:0]      cpu_rdata;

  logic             str_start;
  logic [31:0]      str_base;
  logic [LEN_W-1:0] str_len;
  logic             str_busy;
  logic             str_done;
  logic             str_valid;
  logic [31:0]      str_data;
  logic             str_ready;

  logic [31:0]      mem_addr;
  logic [31:0]      mem_wd;
  logic             mem_we;
  logic [31:0]      mem_rd;

  // Arbiter side
  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
    output cpu_gnt, cpu_rvalid, cpu_rdata,
    input  str_start, str_base, str_len, str_ready,
    output str_busy, str_done, str_valid, str_data,
    output mem_addr, mem_wd, mem_we,
    input  mem_rd
  );

  // Requester / memory side
  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata,
    input  cpu_gnt, cpu_rvalid, cpu_rdata,
    output str_start, str_base, str_len, str_ready,
    input  str_busy, str_done, str_valid, str_data,
    input  mem_addr, mem_wd, mem_we,
    output mem_rd
  );
endinterface

// File: rtl/dmem_arbiter.sv
// Single-port data memory arbiter: CPU has fixed priority, a burst-reading
// stream engine is protected from starvation by a forced-grant counter.
module dmem_arbiter #(
  parameter int LEN_W        = 8,
  parameter int STARVE_LIMIT = 4
) (
  input logic           clk,
  input logic           rst_n,
  dmem_arbiter_if.slave bus
);
  localparam int CNT_W = $clog2(STARVE_LIMIT + 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN} state_t;

  state_t           r_state,  w_state_next;
  logic [31:0]      r_addr,   w_addr_next;
  logic [LEN_W-1:0] r_left,   w_left_next;
  logic [CNT_W-1:0] r_starve, w_starve_next;
  logic             r_valid,  w_valid_next;
  logic [31:0]      r_data,   w_data_next;
  logic             r_done,   w_done_next;
  logic             r_rvalid, w_rvalid_next;
  logic [31:0]      r_rdata,  w_rdata_next;

  logic             w_str_want;
  logic             w_force;
  logic             w_str_gnt;
  logic             w_cpu_gnt;
  logic             w_unused_low;

  // Single-entry output buffer: fetch only if it is empty or being drained now.
  assign w_str_want = (r_state == S_RUN) && (r_left != '0) &&
                      (!r_valid || bus.str_ready);
  assign w_force    = w_str_want && (r_starve == CNT_W'(STARVE_LIMIT));
  assign w_str_gnt  = w_str_want && (!bus.cpu_req || w_force);
  assign w_cpu_gnt  = bus.cpu_req && !w_force;

  assign bus.cpu_gnt    = w_cpu_gnt;
  assign bus.cpu_rvalid = r_rvalid;
  assign bus.cpu_rdata  = r_rdata;
  assign bus.str_busy   = (r_state != S_IDLE);
  assign bus.str_done   = r_done;
  assign bus.str_valid  = r_valid;
  assign bus.str_data   = r_data;
  assign bus.mem_addr   = w_str_gnt ? r_addr : {bus.cpu_addr[31:2], 2'b00};
  assign bus.mem_wd     = bus.cpu_wdata;
  assign bus.mem_we     = w_cpu_gnt & bus.cpu_we;

  assign w_unused_low   = ^{bus.cpu_addr[1:0], bus.str_base[1:0]};

  always_comb begin
    w_state_next  = r_state;
    w_addr_next   = r_addr;
    w_left_next   = r_left;
    w_starve_next = '0;
    w_valid_next  = r_valid;
    w_data_next   = r_data;
    w_done_next   = 1'b0;
    w_rvalid_next = w_cpu_gnt && !bus.cpu_we;
    w_rdata_next  = (w_cpu_gnt && !bus.cpu_we) ? bus.mem_rd : r_rdata;

    if (w_str_want && !w_str_gnt) begin
      w_starve_next = r_starve + 1'b1;
    end

    // A fresh fetch wins over a same-cycle handshake that would empty the buffer.
    if (w_str_gnt) begin
      w_valid_next = 1'b1;
      w_data_next  = bus.mem_rd;
    end else if (r_valid && bus.str_ready) begin
      w_valid_next = 1'b0;
    end

    case (r_state)
      S_IDLE: begin
        if (bus.str_start) begin
          if (bus.str_len != '0) begin
            w_state_next = S_RUN;
            w_addr_next  = {bus.str_base[31:2], 2'b00};
            w_left_next  = bus.str_len;
          end else begin
            w_done_next  = 1'b1;
          end
        end
      end
      S_RUN: begin
        if (w_str_gnt) begin
          w_addr_next = r_addr + 32'd4;
          w_left_next = r_left - 1'b1;
          if (r_left == LEN_W'(1)) begin
            w_state_next = S_DRAIN;
          end
        end
      end
      S_DRAIN: begin
        if (!r_valid || bus.str_ready) begin
          w_done_next  = 1'b1;
          w_state_next = S_IDLE;
        end
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_addr   <= '0;
      r_left   <= '0;
      r_starve <= '0;
      r_valid  <= 1'b0;
      r_data   <= '0;
      r_done   <= 1'b0;
      r_rvalid <= 1'b0;
      r_rdata  <= '0;
    end else begin
      r_state  <= w_state_next;
      r_addr   <= w_addr_next;
      r_left   <= w_left_next;
      r_starve <= w_starve_next;
      r_valid  <= w_valid_next;
      r_data   <= w_data_next;
      r_done   <= w_done_next;
      r_rvalid <= w_rvalid_next;
      r_rdata  <= w_rdata_next;
    end
  end
endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: directed scenarios plus a randomized
// run compared cycle by cycle against a behavioural model of the sharing rules.
module tb_dmem_arbiter;
  localparam int LEN_W        = 8;
  localparam int STARVE_LIMIT = 4;

  logic clk = 1'b0;
  logic rst_n;
  int   checks   = 0;
  int   failures = 0;

  dmem_arbiter_if #(.LEN_W(LEN_W)) bus ();

  dmem_arbiter #(.LEN_W(LEN_W), .STARVE_LIMIT(STARVE_LIMIT)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Data memory: combinational read, write on the clock edge.
  logic [31:0] mem [0:1023];
  assign bus.mem_rd = mem[bus.mem_addr[11:2]];
  always @(posedge clk) begin
    if (bus.mem_we === 1'b1) mem[bus.mem_addr[11:2]] <= bus.mem_wd;
  end

  function automatic logic [31:0] init_word(int idx);
    return 32'h5A5A0000 + 32'(idx);
  endfunction

  // Behavioural model: a burst is "words still to fetch" plus a one-deep buffer.
  logic        m_busy, m_valid, m_done, m_rvalid;
  logic [31:0] m_addr, m_data, m_rdata;
  int unsigned m_left, m_starve;
  logic        e_want, e_str_gnt, e_cpu_gnt;
  logic [31:0] e_mem_addr;

  always_comb begin
    e_want     = m_busy && (m_left != 0) && (!m_valid || bus.str_ready);
    e_str_gnt  = e_want && (!bus.cpu_req || m_starve == STARVE_LIMIT);
    e_cpu_gnt  = bus.cpu_req && !e_str_gnt;
    e_mem_addr = e_str_gnt ? m_addr : (bus.cpu_addr & 32'hFFFF_FFFC);
  end

  always @(posedge clk) begin
    if (!rst_n) begin
      m_busy <= 1'b0; m_valid <= 1'b0; m_done <= 1'b0; m_rvalid <= 1'b0;
      m_addr <= '0;   m_data  <= '0;   m_rdata <= '0;
      m_left <= 0;    m_starve <= 0;
    end else begin
      m_rvalid <= e_cpu_gnt && !bus.cpu_we;
      if (e_cpu_gnt && !bus.cpu_we) m_rdata <= mem[bus.cpu_addr[11:2]];
      m_starve <= (e_want && !e_str_gnt) ? m_starve + 1 : 0;
      m_done   <= 1'b0;
      if (e_str_gnt) begin
        m_data  <= mem[m_addr[11:2]];
        m_valid <= 1'b1;
        m_addr  <= m_addr + 32'd4;
        m_left  <= m_left - 1;
      end else if (m_valid && bus.str_ready) begin
        m_valid <= 1'b0;
      end
      if (m_busy && m_left == 0 && (!m_valid || bus.str_ready)) begin
        m_busy <= 1'b0;
        m_done <= 1'b1;
      end
      if (!m_busy && bus.str_start) begin
        if (bus.str_len != '0) begin
          m_busy <= 1'b1;
          m_addr <= bus.str_base & 32'hFFFF_FFFC;
          m_left <= 32'(bus.str_len);
        end else begin
          m_done <= 1'b1;
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.cpu_req   = 1'b0;
    bus.cpu_we    = 1'b0;
    bus.cpu_addr  = '0;
    bus.cpu_wdata = '0;
    bus.str_start = 1'b0;
    bus.str_base  = '0;
    bus.str_len   = '0;
    bus.str_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    idle_inputs();
    tick();
    tick();
    @(negedge clk);
    checks++;
    if ({bus.cpu_rvalid, bus.str_busy, bus.str_done, bus.str_valid, bus.cpu_gnt} !== 5'b0) begin
      failures++;
      $display("FAIL reset_flags got=%b exp=00000",
               {bus.cpu_rvalid, bus.str_busy, bus.str_done, bus.str_valid, bus.cpu_gnt});
    end
    checks++;
    if (bus.cpu_rdata !== 32'h0) begin
      failures++; $display("FAIL reset_cpu_rdata got=%h exp=00000000", bus.cpu_rdata);
    end
    checks++;
    if (bus.str_data !== 32'h0) begin
      failures++; $display("FAIL reset_str_data got=%h exp=00000000", bus.str_data);
    end
    tick();
    rst_n = 1'b1;
    tick();
    $display("test_reset done");
  endtask

  task automatic test_cpu_access();
    bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = 32'h12;
    @(negedge clk);
    checks++;
    if ({bus.cpu_gnt, bus.mem_we} !== 2'b10 || bus.mem_addr !== 32'h10) begin
      failures++;
      $display("FAIL cpu_rd_req got gnt=%b we=%b addr=%h exp gnt=1 we=0 addr=00000010",
               bus.cpu_gnt, bus.mem_we, bus.mem_addr);
    end
    tick();
    bus.cpu_req = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.cpu_rvalid !== 1'b1 || bus.cpu_rdata !== 32'hDEADBEEF) begin
      failures++;
      $display("FAIL cpu_rd_data got rvalid=%b rdata=%h exp rvalid=1 rdata=deadbeef",
               bus.cpu_rvalid, bus.cpu_rdata);
    end
    tick();
    bus.cpu_req = 1'b1; bus.cpu_we = 1'b1; bus.cpu_addr = 32'h20; bus.cpu_wdata = 32'h12345678;
    @(negedge clk);
    checks++;
    if ({bus.cpu_gnt, bus.mem_we, bus.cpu_rvalid} !== 3'b110 || bus.mem_wd !== 32'h12345678) begin
      failures++;
      $display("FAIL cpu_wr_req got gnt=%b we=%b rvalid=%b wd=%h exp gnt=1 we=1 rvalid=0 wd=12345678",
               bus.cpu_gnt, bus.mem_we, bus.cpu_rvalid, bus.mem_wd);
    end
    tick();
    bus.cpu_req = 1'b0; bus.cpu_we = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.cpu_rvalid !== 1'b0) begin
      failures++; $display("FAIL cpu_wr_no_rvalid got=%b exp=0", bus.cpu_rvalid);
    end
    tick();
    bus.cpu_req = 1'b1; bus.cpu_addr = 32'h23;
    @(negedge clk);
    tick();
    bus.cpu_req = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.cpu_rvalid !== 1'b1 || bus.cpu_rdata !== 32'h12345678) begin
      failures++;
      $display("FAIL cpu_rd_after_wr got rvalid=%b rdata=%h exp rvalid=1 rdata=12345678",
               bus.cpu_rvalid, bus.cpu_rdata);
    end
    tick();
    idle_inputs();
    $display("test_cpu_access done");
  endtask

  task automatic test_burst_basic();
    bus.str_ready = 1'b1; bus.str_base = 32'h100; bus.str_len = 8'd3; bus.str_start = 1'b1;
    @(negedge clk);
    checks++;
    if (bus.str_busy !== 1'b0) begin
      failures++; $display("FAIL burst_busy_c0 got=%b exp=0", bus.str_busy);
    end
    tick();
    bus.str_start = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      logic [31:0] ea;
      logic [2:0]  ef;
      @(negedge clk);
      ea = (k <= 3) ? 32'h100 + 32'(4 * (k - 1)) : 32'h0;
      ef = {(k >= 2 && k <= 4), (k <= 4), (k == 5)};
      checks++;
      if (bus.mem_addr !== ea) begin
        failures++; $display("FAIL burst_addr c%0d got=%h exp=%h", k, bus.mem_addr, ea);
      end
      checks++;
      if ({bus.str_valid, bus.str_busy, bus.str_done} !== ef) begin
        failures++;
        $display("FAIL burst_flags c%0d got vbd=%b exp=%b", k,
                 {bus.str_valid, bus.str_busy, bus.str_done}, ef);
      end
      if (ef[2]) begin
        checks++;
        if (bus.str_data !== init_word(64 + k - 2)) begin
          failures++;
          $display("FAIL burst_data c%0d got=%h exp=%h", k, bus.str_data, init_word(64 + k - 2));
        end
      end
      tick();
    end
    idle_inputs();
    $display("test_burst_basic base=00000100 len=3 done");
  endtask

  task automatic test_starvation();
    logic [31:0] got_q[$];
    bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = 32'h40;
    bus.str_ready = 1'b1; bus.str_base = 32'h200; bus.str_len = 8'd3; bus.str_start = 1'b1;
    tick();
    bus.str_start = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      logic        gk;
      logic [31:0] ea;
      @(negedge clk);
      gk = (k % 5 == 0) && (k <= 15);
      ea = gk ? 32'h200 + 32'(4 * (k / 5 - 1)) : 32'h40;
      checks++;
      if (bus.cpu_gnt !== !gk || bus.mem_addr !== ea) begin
        failures++;
        $display("FAIL starve_grant c%0d got gnt=%b addr=%h exp gnt=%b addr=%h",
                 k, bus.cpu_gnt, bus.mem_addr, !gk, ea);
      end
      checks++;
      if (bus.str_done !== (k == 17)) begin
        failures++; $display("FAIL starve_done c%0d got=%b exp=%b", k, bus.str_done, (k == 17));
      end
      if (bus.str_valid === 1'b1 && bus.str_ready === 1'b1) got_q.push_back(bus.str_data);
      tick();
    end
    checks++;
    if (got_q.size() != 3) begin
      failures++; $display("FAIL starve_count got=%0d exp=3", got_q.size());
    end
    for (int i = 0; i < got_q.size() && i < 3; i++) begin
      checks++;
      if (got_q[i] !== init_word(128 + i)) begin
        failures++; $display("FAIL starve_sample%0d got=%h exp=%h", i, got_q[i], init_word(128 + i));
      end
    end
    idle_inputs();
    $display("test_starvation samples=%0d", got_q.size());
  endtask

  task automatic test_backpressure();
    bus.str_ready = 1'b1; bus.str_base = 32'h300; bus.str_len = 8'd2; bus.str_start = 1'b1;
    tick();
    bus.str_start = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.mem_addr !== 32'h300) begin
      failures++; $display("FAIL bp_first_fetch got=%h exp=00000300", bus.mem_addr);
    end
    tick();
    bus.str_ready = 1'b0;
    for (int k = 2; k <= 11; k++) begin
      @(negedge clk);
      checks++;
      if ({bus.str_valid, bus.str_busy} !== 2'b11 || bus.str_data !== init_word(192) ||
          bus.mem_addr !== 32'h0) begin
        failures++;
        $display("FAIL bp_hold c%0d got v=%b b=%b data=%h addr=%h exp v=1 b=1 data=%h addr=00000000",
                 k, bus.str_valid, bus.str_busy, bus.str_data, bus.mem_addr, init_word(192));
      end
      tick();
    end
    bus.str_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (bus.mem_addr !== 32'h304) begin
      failures++; $display("FAIL bp_second_fetch got=%h exp=00000304", bus.mem_addr);
    end
    tick();
    @(negedge clk);
    checks++;
    if (bus.str_valid !== 1'b1 || bus.str_data !== init_word(193)) begin
      failures++;
      $display("FAIL bp_second_data got v=%b data=%h exp v=1 data=%h",
               bus.str_valid, bus.str_data, init_word(193));
    end
    tick();
    @(negedge clk);
    checks++;
    if ({bus.str_done, bus.str_busy, bus.str_valid} !== 3'b100) begin
      failures++;
      $display("FAIL bp_end got dbv=%b exp=100", {bus.str_done, bus.str_busy, bus.str_valid});
    end
    tick();
    idle_inputs();
    $display("test_backpressure done");
  endtask

  task automatic test_len0_ignore_wrap();
    bus.str_start = 1'b1; bus.str_base = 32'h600; bus.str_len = 8'd0; bus.str_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (bus.str_done !== 1'b0) begin
      failures++; $display("FAIL len0_done_c0 got=%b exp=0", bus.str_done);
    end
    tick();
    bus.str_start = 1'b0;
    @(negedge clk);
    checks++;
    if ({bus.str_done, bus.str_busy} !== 2'b10 || bus.mem_addr !== 32'h0) begin
      failures++;
      $display("FAIL len0_pulse got d=%b b=%b addr=%h exp d=1 b=0 addr=00000000",
               bus.str_done, bus.str_busy, bus.mem_addr);
    end
    tick();
    @(negedge clk);
    checks++;
    if ({bus.str_done, bus.str_busy} !== 2'b00) begin
      failures++; $display("FAIL len0_after got db=%b exp=00", {bus.str_done, bus.str_busy});
    end
    tick();
    bus.cpu_addr = 32'h80;
    bus.str_start = 1'b1; bus.str_base = 32'hFFFF_FFFC; bus.str_len = 8'd2;
    tick();
    bus.str_base = 32'h500; bus.str_len = 8'd5;
    @(negedge clk);
    checks++;
    if (bus.mem_addr !== 32'hFFFF_FFFC) begin
      failures++; $display("FAIL wrap_fetch0 got=%h exp=fffffffc", bus.mem_addr);
    end
    tick();
    bus.str_start = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.mem_addr !== 32'h0 || bus.str_data !== init_word(1023)) begin
      failures++;
      $display("FAIL wrap_fetch1 got addr=%h data=%h exp addr=00000000 data=%h",
               bus.mem_addr, bus.str_data, init_word(1023));
    end
    tick();
    @(negedge clk);
    checks++;
    if (bus.mem_addr !== 32'h80 || bus.str_data !== init_word(0)) begin
      failures++;
      $display("FAIL wrap_drain got addr=%h data=%h exp addr=00000080 data=%h",
               bus.mem_addr, bus.str_data, init_word(0));
    end
    tick();
    @(negedge clk);
    checks++;
    if ({bus.str_done, bus.str_busy} !== 2'b10) begin
      failures++; $display("FAIL wrap_done got db=%b exp=10", {bus.str_done, bus.str_busy});
    end
    tick();
    @(negedge clk);
    checks++;
    if ({bus.str_done, bus.str_busy} !== 2'b00) begin
      failures++; $display("FAIL busy_start_ignored got db=%b exp=00", {bus.str_done, bus.str_busy});
    end
    tick();
    idle_inputs();
    $display("test_len0_ignore_wrap done");
  endtask

  task automatic test_reset_midburst();
    bus.str_ready = 1'b1; bus.str_base = 32'h400; bus.str_len = 8'd4; bus.str_start = 1'b1;
    tick();
    bus.str_start = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.mem_addr !== 32'h400) begin
      failures++; $display("FAIL rstmid_fetch got=%h exp=00000400", bus.mem_addr);
    end
    tick();
    rst_n = 1'b0;
    @(negedge clk);
    tick();
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if ({bus.str_busy, bus.str_valid, bus.str_done} !== 3'b000) begin
      failures++;
      $display("FAIL rstmid_abort got bvd=%b exp=000", {bus.str_busy, bus.str_valid, bus.str_done});
    end
    tick();
    bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = 32'h10;
    @(negedge clk);
    checks++;
    if (bus.str_done !== 1'b0 || bus.cpu_gnt !== 1'b1) begin
      failures++;
      $display("FAIL rstmid_quiet got done=%b gnt=%b exp done=0 gnt=1", bus.str_done, bus.cpu_gnt);
    end
    tick();
    bus.cpu_req = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.cpu_rvalid !== 1'b1 || bus.cpu_rdata !== 32'hDEADBEEF || bus.str_done !== 1'b0) begin
      failures++;
      $display("FAIL rstmid_cpu_read got rvalid=%b rdata=%h done=%b exp rvalid=1 rdata=deadbeef done=0",
               bus.cpu_rvalid, bus.cpu_rdata, bus.str_done);
    end
    tick();
    idle_inputs();
    $display("test_reset_midburst done");
  endtask

  task automatic test_random();
    logic last_gnt = 1'b0;
    int   n_done   = 0;
    rst_n = 1'b0;
    idle_inputs();
    tick();
    rst_n = 1'b1;
    for (int cyc = 0; cyc < 4000; cyc++) begin
      if (!(bus.cpu_req === 1'b1 && !last_gnt)) begin
        bus.cpu_req   = ($urandom_range(0, 99) < 55);
        bus.cpu_we    = 1'($urandom_range(0, 1));
        bus.cpu_addr  = 32'($urandom_range(0, 511));
        bus.cpu_wdata = $urandom;
      end
      bus.str_ready = ($urandom_range(0, 99) < 70);
      bus.str_start = ($urandom_range(0, 99) < 10);
      bus.str_base  = ($urandom_range(0, 15) == 0) ? 32'hFFFF_FFF0 + 32'($urandom_range(0, 15))
                                                   : 32'($urandom_range(0, 511));
      bus.str_len   = LEN_W'($urandom_range(0, 6));
      rst_n         = ($urandom_range(0, 399) != 0);
      @(negedge clk);
      checks++;
      if ({bus.cpu_gnt, bus.mem_we} !== {e_cpu_gnt, e_cpu_gnt & bus.cpu_we} ||
          bus.mem_addr !== e_mem_addr) begin
        failures++;
        $display("FAIL rand_arb cyc%0d got gnt=%b we=%b addr=%h exp gnt=%b we=%b addr=%h", cyc,
                 bus.cpu_gnt, bus.mem_we, bus.mem_addr, e_cpu_gnt, e_cpu_gnt & bus.cpu_we, e_mem_addr);
      end
      checks++;
      if (bus.cpu_rvalid !== m_rvalid || bus.cpu_rdata !== m_rdata) begin
        failures++;
        $display("FAIL rand_cpu_rd cyc%0d got rvalid=%b rdata=%h exp rvalid=%b rdata=%h", cyc,
                 bus.cpu_rvalid, bus.cpu_rdata, m_rvalid, m_rdata);
      end
      checks++;
      if ({bus.str_valid, bus.str_busy, bus.str_done} !== {m_valid, m_busy, m_done} ||
          bus.str_data !== m_data) begin
        failures++;
        $display("FAIL rand_stream cyc%0d got vbd=%b data=%h exp vbd=%b data=%h", cyc,
                 {bus.str_valid, bus.str_busy, bus.str_done}, bus.str_data,
                 {m_valid, m_busy, m_done}, m_data);
      end
      if (bus.str_done === 1'b1) begin
        n_done++;
        $display("rand burst end cyc=%0d", cyc);
      end
      last_gnt = (bus.cpu_gnt === 1'b1);
      tick();
    end
    rst_n = 1'b1;
    idle_inputs();
    checks++;
    if (n_done < 5) begin
      failures++; $display("FAIL rand_progress got bursts=%0d exp>=5", n_done);
    end
    tick();
    $display("test_random bursts=%0d", n_done);
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = init_word(i);
    mem[4] = 32'hDEADBEEF;
    rst_n = 1'b0;
    idle_inputs();
    test_reset();
    test_cpu_access();
    test_burst_basic();
    test_starvation();
    test_backpressure();
    test_len0_ignore_wrap();
    test_reset_midburst();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Shares the single-port byte-addressed data memory between two requesters: the CPU load/store port and a waveform streaming engine that bursts sample words out to the function-generator output path.
- Sits between the datapath/stream logic and the data memory. Drives the memory's address, write-data and write-enable inputs, and samples its combinational read data.
- The CPU has fixed priority. A starvation counter guarantees the stream forward progress.

Parameters:
- LEN_W, 8, width of burst length field (max burst = 2^LEN_W - 1 words)
- STARVE_LIMIT, 4, consecutive denied stream cycles before the stream is forced a grant (>=1)

Ports:
- clk  in  1  clock, all state updates on rising edge
- rst_n  in  1  synchronous active-low reset
- cpu_req  in  1  CPU access request, held until cpu_gnt
- cpu_we  in  1  1 = word write, 0 = word read
- cpu_addr  in  32  byte address, low 2 bits ignored
- cpu_wdata  in  32  write data
- cpu_gnt  out  1  combinational grant; access performed this cycle
- cpu_rvalid  out  1  registered, read data valid (one cycle)
- cpu_rdata  out  32  registered read data
- str_start  in  1  start burst (sampled only when idle)
- str_base  in  32  burst base byte address
- str_len  in  LEN_W  burst length in words
- str_busy  out  1  burst in progress
- str_done  out  1  one-cycle pulse at burst end
- str_valid  out  1  sample available
- str_data  out  32  sample word
- str_ready  in  1  consumer accepts sample
- mem_addr  out  32  to memory address, {addr[31:2],2'b00}
- mem_wd  out  32  to memory write data
- mem_we  out  1  to memory write enable
- mem_rd  in  32  from memory combinational read data

Behaviour:
- Reset (rst_n=0 at posedge) clears the following to 0:
  - cpu_rvalid, cpu_rdata, str_busy, str_done, str_valid, str_data
  - stream address/count registers and starvation counter
  - FSM state, which returns to S_IDLE
- Reset mid-burst aborts the burst silently: no str_done, the sample is dropped.
- Stream FSM states: S_IDLE, S_RUN, S_DRAIN.
  - S_IDLE + str_start:
    - str_len!=0: latch base (word-aligned) and remaining=str_len; go to S_RUN; str_busy=1 from the next cycle.
    - str_len==0: str_done pulses the next cycle, FSM stays in S_IDLE, no memory access.
  - str_start is ignored when not in S_IDLE.
  - S_RUN: the stream wants the memory when remaining!=0 AND (str_valid==0 OR str_ready==1). This is a single-entry output buffer.
    - On a stream grant: str_data<=mem_rd, str_valid<=1, addr+=4 (wraps modulo 2^32), remaining-=1.
    - When the last word is fetched, go to S_DRAIN.
  - S_DRAIN: wait until str_valid==0, or until str_valid && str_ready in the same cycle. Then str_done=1 for one cycle, str_busy=0, go to S_IDLE.
- str_valid holds with str_data stable until str_ready. str_valid clears on a str_ready handshake unless a new fetch lands in the same cycle.
- Arbitration (combinational, same cycle):
  - Default: cpu_gnt=cpu_req; the stream is granted only when cpu_req=0.
  - Starvation counter increments each cycle the stream wants access but is denied. It clears on a stream grant or when the stream does not want access.
  - When counter==STARVE_LIMIT: stream granted, cpu_gnt=0 for that cycle, counter cleared.
- Memory mux:
  - mem_addr = granted requester address, word-aligned; CPU address when nothing is granted.
  - mem_we = cpu_gnt & cpu_we.
  - mem_wd = cpu_wdata.
  - The stream never writes.
- CPU read: on a cpu_gnt cycle with cpu_we=0, cpu_rdata<=mem_rd at that edge and cpu_rvalid=1 for one cycle (latency 1). Writes produce no rvalid.
- Exactly one access per cycle. A CPU write and a stream read to the same word occur in different cycles, in grant order; a read after the write sees the new data.

Test Plan:
- Memory preloaded word[0x10]=0xDEADBEEF; CPU read addr 0x12 with stream idle -> cpu_gnt same cycle, mem_addr=0x10, next cycle cpu_rvalid=1, cpu_rdata=0xDEADBEEF.
- Burst base=0x100, len=3, str_ready=1, CPU idle -> fetches 0x100/0x104/0x108 on consecutive cycles, three str_valid beats, str_done pulse one cycle after last accept, str_busy low after.
- CPU requests every cycle during burst, STARVE_LIMIT=4 -> stream granted every 5th cycle with cpu_gnt=0 that cycle; all 3 samples eventually delivered in order.
- str_ready held low for 10 cycles after first sample -> exactly one fetch, str_data stable, no memory access by stream until ready; then the burst completes normally.
- str_len=0 start -> str_done pulse next cycle, no mem access; str_start during busy -> ignored; base=0xFFFFFFFC len=2 -> second fetch at 0x00000000.
- rst_n=0 mid-burst (after 1 of 4 words) -> next cycle str_busy=0, str_valid=0, no str_done; a subsequent CPU read works with latency 1.
